// File: rtl/dmem_line_responder.sv
// Line-granular data memory responder: accepts one read/write request, waits LATENCY
// cycles, then commits the write or returns the line alongside a one-cycle ack.
module dmem_line_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state;
  logic [7:0]        count;
  logic              cap_write;
  logic [IDX_W-1:0]  cap_idx;
  logic [LINE_W-1:0] cap_data;

  logic [LINE_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  in_idx;
  logic              commit;
  logic              commit_write;
  logic [IDX_W-1:0]  commit_idx;
  logic [LINE_W-1:0] commit_data;
  logic              unused_addr;

  assign in_idx      = addr_i[OFF_W+IDX_W-1:OFF_W];
  assign unused_addr = ^{addr_i[ADDR_W-1:OFF_W+IDX_W], addr_i[OFF_W-1:0]};

  // The edge that enters ACK is the commit edge; with LATENCY=1 that is the
  // acceptance edge itself, so the live inputs stand in for the captured copy.
  always_comb begin
    commit       = (state == WAIT) && (count == 8'd1);
    commit_write = cap_write;
    commit_idx   = cap_idx;
    commit_data  = cap_data;
    if (LATENCY == 1 && state == IDLE && enable_i) begin
      commit       = 1'b1;
      commit_write = write_i;
      commit_idx   = in_idx;
      commit_data  = data_i;
    end
  end

  // Array is deliberately left out of reset; gating with rst_i keeps an
  // in-reset acceptance from ever landing in memory.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && commit_write)
      mem[commit_idx] <= commit_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      count     <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_data  <= '0;
      ack_o     <= 1'b0;
      data_o    <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            cap_write <= write_i;
            cap_idx   <= in_idx;
            cap_data  <= data_i;
            count     <= 8'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT:    count <= count - 8'd1;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        state <= ACK;
        ack_o <= 1'b1;
        if (!commit_write)
          data_o <= mem[commit_idx];
      end
    end
  end

endmodule
